s_axis_rq_arbiter: RTL and testbench

S_AXIS_RQ_ARBITER -- requirements
Module: s_axis_rq_arbiter

---
 rtl/litepcie_rq_pkg.sv | 32 +++
 rtl/axis_reg_slice.sv | 51 +++++
 rtl/s_axis_rq_arbiter.sv | 151 +++++++++++++++
 tb/tb_s_axis_rq_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/litepcie_rq_pkg.sv
// -----------------------------------------------------------------------------
// litepcie_rq_pkg
// Shared definitions for the requester-request (RQ) stream arbiter:
//   - NUM_RQ_PORTS   : number of requester streams merged by the arbiter
//   - RQ_USER_WIDTH  : width of the tuser sideband carried with every beat
//   - PKT_CNT_WIDTH  : width of the per-port completed-TLP counters
//   - rq_arb_state_t : arbiter FSM encoding (IDLE = no grant, LOCKED = held)
//   - rr_pick()      : two-port round-robin choice used while IDLE
// -----------------------------------------------------------------------------
package litepcie_rq_pkg;

   localparam int NUM_RQ_PORTS  = 2;
   localparam int RQ_USER_WIDTH = 4;
   localparam int PKT_CNT_WIDTH = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } rq_arb_state_t;

   // Returns the port index to grant. On a tie the port that did not win
   // last time is chosen; with only one requester that one is chosen.
   // With no requester the result is 0 and is qualified elsewhere.
   function automatic logic rr_pick(input logic i_v0, input logic i_v1,
                                    input logic i_last_grant);
      if (i_v0 && i_v1) begin
         return ~i_last_grant;
      end
      return i_v1;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// One-stage valid/ready register. A beat accepted on the slave side appears
// on the master side one cycle later and is held stable until taken.
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_s_valid/o_s_ready : upstream handshake, i_s_data payload in
//   o_m_valid/i_m_ready : downstream handshake, o_m_data payload out
// -----------------------------------------------------------------------------
module axis_reg_slice #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [WIDTH-1:0] i_s_data,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic [WIDTH-1:0] o_m_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_load;

   // Room for a new beat when empty or when the held beat leaves this cycle.
   assign o_s_ready = ~r_valid | i_m_ready;
   assign w_load    = i_s_valid & o_s_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
      end else if (i_m_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Payload is don't-care while empty, so it carries no reset.
   always_ff @(posedge i_clk) begin
      if (w_load) begin
         r_data <= i_s_data;
      end
   end

   assign o_m_valid = r_valid;
   assign o_m_data  = r_data;

endmodule

// File: rtl/s_axis_rq_arbiter.sv
// -----------------------------------------------------------------------------
// s_axis_rq_arbiter
// Merges two AXI-Stream requester-request streams into one, packet by packet.
// A grant is made combinationally while IDLE (round-robin on ties) and is
// held until the tlast beat of that TLP is accepted. Merged beats leave
// through a one-stage output register.
// Ports:
//   user_clk, user_reset       : clock, asynchronous active-high reset
//   s0_axis_rq_* / s1_axis_rq_*: requester streams (tdata/tkeep/tlast/tuser/
//                                tvalid in, tready out)
//   m_axis_rq_*                : merged stream (tready in)
//   pkt_cnt0 / pkt_cnt1        : completed TLPs per port, wrapping
// -----------------------------------------------------------------------------
module s_axis_rq_arbiter
   import litepcie_rq_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                     user_clk,
   input  logic                     user_reset,
   input  logic [DATA_WIDTH-1:0]    s0_axis_rq_tdata,
   input  logic [KEEP_WIDTH-1:0]    s0_axis_rq_tkeep,
   input  logic                     s0_axis_rq_tlast,
   input  logic [RQ_USER_WIDTH-1:0] s0_axis_rq_tuser,
   input  logic                     s0_axis_rq_tvalid,
   output logic                     s0_axis_rq_tready,
   input  logic [DATA_WIDTH-1:0]    s1_axis_rq_tdata,
   input  logic [KEEP_WIDTH-1:0]    s1_axis_rq_tkeep,
   input  logic                     s1_axis_rq_tlast,
   input  logic [RQ_USER_WIDTH-1:0] s1_axis_rq_tuser,
   input  logic                     s1_axis_rq_tvalid,
   output logic                     s1_axis_rq_tready,
   output logic [DATA_WIDTH-1:0]    m_axis_rq_tdata,
   output logic [KEEP_WIDTH-1:0]    m_axis_rq_tkeep,
   output logic                     m_axis_rq_tlast,
   output logic [RQ_USER_WIDTH-1:0] m_axis_rq_tuser,
   output logic                     m_axis_rq_tvalid,
   input  logic                     m_axis_rq_tready,
   output logic [PKT_CNT_WIDTH-1:0] pkt_cnt0,
   output logic [PKT_CNT_WIDTH-1:0] pkt_cnt1
);

   localparam int PAYLOAD_W = 1 + RQ_USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

   rq_arb_state_t        r_state, w_state_next;
   logic                 r_last_grant, w_last_grant_next;
   logic                 r_lock_port, w_lock_port_next;
   logic                 w_grant_valid;
   logic                 w_sel;
   logic                 w_fwd_valid;
   logic                 w_fwd_last;
   logic                 w_accept;
   logic                 w_slice_ready;
   logic [PAYLOAD_W-1:0] w_fwd_payload;
   logic [PAYLOAD_W-1:0] w_out_payload;

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_lock_port  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_last_grant <= w_last_grant_next;
         r_lock_port  <= w_lock_port_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_last_grant_next = r_last_grant;
      w_lock_port_next  = r_lock_port;
      w_grant_valid     = 1'b0;
      w_sel             = r_lock_port;

      case (r_state)
         ST_IDLE: begin
            w_grant_valid = s0_axis_rq_tvalid | s1_axis_rq_tvalid;
            w_sel         = rr_pick(s0_axis_rq_tvalid, s1_axis_rq_tvalid,
                                    r_last_grant);
         end
         ST_LOCKED: begin
            w_grant_valid = 1'b1;
         end
         default: begin
            w_grant_valid = 1'b0;
         end
      endcase

      // The grant is combinational, so it must also be killed while reset
      // is held to keep both tready outputs low.
      w_grant_valid = w_grant_valid & ~user_reset;

      w_fwd_valid = w_grant_valid & (w_sel ? s1_axis_rq_tvalid : s0_axis_rq_tvalid);
      w_fwd_last  = w_sel ? s1_axis_rq_tlast : s0_axis_rq_tlast;
      w_accept    = w_fwd_valid & w_slice_ready;

      s0_axis_rq_tready = w_grant_valid & ~w_sel & w_slice_ready;
      s1_axis_rq_tready = w_grant_valid &  w_sel & w_slice_ready;

      // tlast releases the grant so the next cycle re-arbitrates at once;
      // any other beat locks (or keeps) the grant on the selected port.
      if (w_accept) begin
         w_last_grant_next = w_sel;
         if (w_fwd_last) begin
            w_state_next = ST_IDLE;
         end else begin
            w_state_next     = ST_LOCKED;
            w_lock_port_next = w_sel;
         end
      end
   end

   assign w_fwd_payload = w_sel ?
      {s1_axis_rq_tlast, s1_axis_rq_tuser, s1_axis_rq_tkeep, s1_axis_rq_tdata} :
      {s0_axis_rq_tlast, s0_axis_rq_tuser, s0_axis_rq_tkeep, s0_axis_rq_tdata};

   axis_reg_slice #(
      .WIDTH (PAYLOAD_W)
   ) u_out_reg (
      .i_clk     (user_clk),
      .i_rst     (user_reset),
      .i_s_valid (w_fwd_valid),
      .o_s_ready (w_slice_ready),
      .i_s_data  (w_fwd_payload),
      .o_m_valid (m_axis_rq_tvalid),
      .i_m_ready (m_axis_rq_tready),
      .o_m_data  (w_out_payload)
   );

   assign {m_axis_rq_tlast, m_axis_rq_tuser, m_axis_rq_tkeep, m_axis_rq_tdata} = w_out_payload;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RQ_PORTS; gi++) begin : g_cnt
         logic [PKT_CNT_WIDTH-1:0] r_cnt;
         always_ff @(posedge user_clk or posedge user_reset) begin
            if (user_reset) begin
               r_cnt <= '0;
            end else if (w_accept && w_fwd_last && (w_sel == 1'(gi))) begin
               r_cnt <= r_cnt + PKT_CNT_WIDTH'(1);
            end
         end
      end
   endgenerate

   assign pkt_cnt0 = g_cnt[0].r_cnt;
   assign pkt_cnt1 = g_cnt[1].r_cnt;

endmodule

// File: tb/tb_s_axis_rq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s_axis_rq_arbiter
// Self-checking bench: per-port source queues drive the requester streams,
// expected output beats go to a scoreboard queue in the order the merged
// stream must produce them, and every output handshake pops and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_s_axis_rq_arbiter;

   localparam int DW = 256;
   localparam int KW = DW / 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [3:0]    user;
      logic          last;
   } beat_t;

   typedef struct {
      int len0;
      int len1;
      int exp_first;
   } vec_t;

   logic          user_clk = 1'b0;
   logic          user_reset = 1'b0;
   logic [DW-1:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
   logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0, m_tkeep;
   logic [3:0]    s0_tuser = '0, s1_tuser = '0, m_tuser;
   logic          s0_tlast = 1'b0, s1_tlast = 1'b0, m_tlast;
   logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0, m_tvalid;
   logic          s0_tready, s1_tready;
   logic          m_tready = 1'b1;
   logic [15:0]   pkt_cnt0, pkt_cnt1;

   always #5 user_clk = ~user_clk;

   s_axis_rq_arbiter #(
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW)
   ) dut (
      .user_clk          (user_clk),
      .user_reset        (user_reset),
      .s0_axis_rq_tdata  (s0_tdata),
      .s0_axis_rq_tkeep  (s0_tkeep),
      .s0_axis_rq_tlast  (s0_tlast),
      .s0_axis_rq_tuser  (s0_tuser),
      .s0_axis_rq_tvalid (s0_tvalid),
      .s0_axis_rq_tready (s0_tready),
      .s1_axis_rq_tdata  (s1_tdata),
      .s1_axis_rq_tkeep  (s1_tkeep),
      .s1_axis_rq_tlast  (s1_tlast),
      .s1_axis_rq_tuser  (s1_tuser),
      .s1_axis_rq_tvalid (s1_tvalid),
      .s1_axis_rq_tready (s1_tready),
      .m_axis_rq_tdata   (m_tdata),
      .m_axis_rq_tkeep   (m_tkeep),
      .m_axis_rq_tlast   (m_tlast),
      .m_axis_rq_tuser   (m_tuser),
      .m_axis_rq_tvalid  (m_tvalid),
      .m_axis_rq_tready  (m_tready),
      .pkt_cnt0          (pkt_cnt0),
      .pkt_cnt1          (pkt_cnt1)
   );

   beat_t       src0[$], src1[$], stg0[$], stg1[$], expq[$];
   int          acc_log[$];
   int          exp_acc[$];
   bit          out_log[$], lastout_log[$];
   int          total = 0;
   int          bad = 0;
   int          rel = 0;
   int          en1_at = 0;
   bit          mr_toggle = 1'b0;
   bit          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [15:0] mcnt0 = '0, mcnt1 = '0;
   vec_t        vecs[6];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic push_tlp(input int port, input int len, input logic [7:0] base);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
         b.data[7:0] = base + 8'(k);
         b.keep = $urandom;
         b.user = 4'($urandom_range(0, 15));
         b.last = (k == len - 1);
         if (port == 0) begin src0.push_back(b); stg0.push_back(b); end
         else           begin src1.push_back(b); stg1.push_back(b); end
      end
      if (len > 0) begin
         if (port == 0) mcnt0++;
         else           mcnt1++;
      end
   endtask

   // Staged TLPs enter the scoreboard in the order the merged stream must show them.
   task automatic commit(input int first);
      if (first == 0) begin
         foreach (stg0[k]) expq.push_back(stg0[k]);
         foreach (stg1[k]) expq.push_back(stg1[k]);
      end else begin
         foreach (stg1[k]) expq.push_back(stg1[k]);
         foreach (stg0[k]) expq.push_back(stg0[k]);
      end
      stg0.delete();
      stg1.delete();
   endtask

   task automatic apply();
      s0_tvalid = (src0.size() > 0);
      if (s0_tvalid) begin
         s0_tdata = src0[0].data; s0_tkeep = src0[0].keep;
         s0_tuser = src0[0].user; s0_tlast = src0[0].last;
      end
      s1_tvalid = (src1.size() > 0) && (rel >= en1_at);
      if (src1.size() > 0) begin
         s1_tdata = src1[0].data; s1_tkeep = src1[0].keep;
         s1_tuser = src1[0].user; s1_tlast = src1[0].last;
      end
      m_tready = mr_toggle ? ((rel % 2) == 0) : 1'b1;
   endtask

   // One clock: drive after the falling edge, sample 2 ns later, and account
   // for the handshakes that the coming rising edge will complete.
   task automatic tick();
      logic  r0, r1, mv;
      beat_t e;
      apply();
      #2;
      r0 = s0_tready;
      r1 = s1_tready;
      mv = m_tvalid;
      chk("one_ready", {255'd0, r0 & r1}, '0);
      if (prev_stall) begin
         chk("stall_valid", {255'd0, mv}, 1);
         chk("stall_data", m_tdata, prev_data);
      end
      if (mv && !m_tready) begin
         chk("stall_s0_ready", {255'd0, r0}, 0);
         chk("stall_s1_ready", {255'd0, r1}, 0);
      end
      if (mv && m_tready) begin
         if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got data %0h want no beat", m_tdata);
         end else begin
            e = expq.pop_front();
            chk("out_data", m_tdata, e.data);
            chk("out_keep", {224'd0, m_tkeep}, {224'd0, e.keep});
            chk("out_user", {252'd0, m_tuser}, {252'd0, e.user});
            chk("out_last", {255'd0, m_tlast}, {255'd0, e.last});
         end
      end
      if (s0_tvalid && r0) begin acc_log.push_back(0); void'(src0.pop_front()); end
      else if (s1_tvalid && r1) begin acc_log.push_back(1); void'(src1.pop_front()); end
      else acc_log.push_back(-1);
      out_log.push_back(mv);
      lastout_log.push_back(mv && m_tlast);
      prev_stall = mv && !m_tready;
      prev_data  = m_tdata;
      rel++;
      @(negedge user_clk);
   endtask

   task automatic start();
      rel = 0; en1_at = 0; mr_toggle = 1'b0;
      acc_log.delete(); exp_acc.delete(); out_log.delete(); lastout_log.delete();
   endtask

   task automatic run_until_idle(input int max_cycles);
      int n = 0;
      while ((src0.size() > 0 || src1.size() > 0 || expq.size() > 0) && n < max_cycles) begin
         tick();
         n++;
      end
      total++;
      if (src0.size() > 0 || src1.size() > 0 || expq.size() > 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d beats pending after %0d cycles want 0",
                  expq.size(), max_cycles);
         src0.delete(); src1.delete(); expq.delete();
      end
   endtask

   task automatic exp_run(input int port, input int n);
      for (int k = 0; k < n; k++) exp_acc.push_back(port);
   endtask

   task automatic chk_acc(input string name);
      int bad_at = -1;
      int got = -2;
      for (int k = 0; k < exp_acc.size(); k++) begin
         if (bad_at < 0 && (k >= acc_log.size() || acc_log[k] != exp_acc[k])) begin
            bad_at = k;
            got = (k < acc_log.size()) ? acc_log[k] : -2;
         end
      end
      total++;
      if (bad_at >= 0) begin
         bad++;
         $display("FAIL %s: cycle %0d accepted port %0d want %0d", name, bad_at, got, exp_acc[bad_at]);
      end
   endtask

   task automatic do_reset();
      user_reset = 1'b1;
      s0_tvalid = 1'b1;
      s1_tvalid = 1'b1;
      @(negedge user_clk);
      #1;
      chk("rst_m_tvalid", {255'd0, m_tvalid}, 0);
      chk("rst_s0_tready", {255'd0, s0_tready}, 0);
      chk("rst_s1_tready", {255'd0, s1_tready}, 0);
      chk("rst_cnt0", {240'd0, pkt_cnt0}, 0);
      chk("rst_cnt1", {240'd0, pkt_cnt1}, 0);
      src0.delete(); src1.delete(); stg0.delete(); stg1.delete(); expq.delete();
      mcnt0 = '0; mcnt1 = '0; prev_stall = 1'b0;
      @(negedge user_clk);
      user_reset = 1'b0;
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
   endtask

   initial begin
      // len0, len1, expected first port on the merged stream
      vecs[0] = '{2, 3, 0};
      vecs[1] = '{0, 1, 1};
      vecs[2] = '{1, 2, 0};
      vecs[3] = '{3, 0, 0};
      vecs[4] = '{2, 1, 1};
      vecs[5] = '{1, 1, 1};

      do_reset();

      for (int i = 0; i < 6; i++) begin
         start();
         push_tlp(0, vecs[i].len0, 8'(16 * i));
         push_tlp(1, vecs[i].len1, 8'(16 * i + 8));
         commit(vecs[i].exp_first);
         if (vecs[i].exp_first == 0) begin
            exp_run(0, vecs[i].len0); exp_run(1, vecs[i].len1);
         end else begin
            exp_run(1, vecs[i].len1); exp_run(0, vecs[i].len0);
         end
         run_until_idle(50);
         chk_acc($sformatf("vec%0d_order", i));
         chk($sformatf("vec%0d_cnt0", i), {240'd0, pkt_cnt0}, {240'd0, mcnt0});
         chk($sformatf("vec%0d_cnt1", i), {240'd0, pkt_cnt1}, {240'd0, mcnt1});
      end

      // Single 3-beat TLP on port 0.
      do_reset();
      start();
      push_tlp(0, 3, 8'hA0);
      commit(0);
      exp_run(0, 3);
      run_until_idle(20);
      tick();
      chk_acc("a_accept");
      chk("a_valid_c0", {255'd0, out_log[0]}, 0);
      chk("a_valid_c1_3", {253'd0, out_log[1], out_log[2], out_log[3]}, 3'b111);
      chk("a_last_c1_3", {253'd0, lastout_log[1], lastout_log[2], lastout_log[3]}, 3'b001);
      chk("a_valid_c4", {255'd0, out_log[4]}, 0);
      chk("a_cnt0", {240'd0, pkt_cnt0}, 1);

      // Ties right after reset alternate 0,1,0,1,...
      do_reset();
      start();
      for (int k = 0; k < 4; k++) begin
         push_tlp(0, 1, 8'(8'h40 + k));
         push_tlp(1, 1, 8'(8'h50 + k));
         commit(0);
         exp_run(0, 1);
         exp_run(1, 1);
      end
      run_until_idle(30);
      chk_acc("b_alternate");
      chk("b_cnt0", {240'd0, pkt_cnt0}, 4);
      chk("b_cnt1", {240'd0, pkt_cnt1}, 4);

      // Port 1 arrives mid-packet: held off, then granted with no gap.
      start();
      en1_at = 1;
      push_tlp(0, 4, 8'h60);
      push_tlp(1, 1, 8'h70);
      commit(0);
      exp_run(0, 4);
      exp_run(1, 1);
      run_until_idle(30);
      chk_acc("c_lock_then_switch");
      chk("c_cnt0", {240'd0, pkt_cnt0}, {240'd0, mcnt0});
      chk("c_cnt1", {240'd0, pkt_cnt1}, {240'd0, mcnt1});

      // Downstream ready toggling 1,0,1,0 during a 4-beat TLP.
      start();
      mr_toggle = 1'b1;
      push_tlp(0, 4, 8'h80);
      commit(0);
      exp_acc.push_back(0); exp_acc.push_back(-1); exp_acc.push_back(0);
      exp_acc.push_back(-1); exp_acc.push_back(0); exp_acc.push_back(-1);
      exp_acc.push_back(0);
      run_until_idle(30);
      chk_acc("d_stall_accept");
      chk("d_cnt0", {240'd0, pkt_cnt0}, {240'd0, mcnt0});

      // Reset asserted during beat 2 of a 4-beat TLP.
      start();
      push_tlp(0, 4, 8'h90);
      commit(0);
      tick();
      tick();
      chk("e_cnt0_pre", {240'd0, pkt_cnt0}, {240'd0, 16'(mcnt0 - 16'd1)});
      user_reset = 1'b1;
      #1;
      chk("e_m_tvalid", {255'd0, m_tvalid}, 0);
      chk("e_s0_tready", {255'd0, s0_tready}, 0);
      chk("e_cnt0", {240'd0, pkt_cnt0}, 0);
      chk("e_cnt1", {240'd0, pkt_cnt1}, 0);
      src0.delete(); src1.delete(); stg0.delete(); stg1.delete(); expq.delete();
      mcnt0 = '0; mcnt1 = '0; prev_stall = 1'b0;
      s0_tvalid = 1'b0;
      @(negedge user_clk);
      user_reset = 1'b0;
      start();
      push_tlp(1, 2, 8'hB0);
      push_tlp(0, 1, 8'hC0);
      commit(0);
      exp_run(0, 1);
      exp_run(1, 2);
      run_until_idle(20);
      chk_acc("e_after_reset");
      chk("e_cnt0_post", {240'd0, pkt_cnt0}, 1);
      chk("e_cnt1_post", {240'd0, pkt_cnt1}, 1);

      // Counter wrap on port 1.
      do_reset();
      start();
      for (int k = 0; k < 65535; k++) begin
         push_tlp(1, 1, 8'(k));
         commit(1);
      end
      run_until_idle(70000);
      chk("f_cnt1_ffff", {240'd0, pkt_cnt1}, {240'd0, 16'hFFFF});
      push_tlp(1, 1, 8'hEE);
      commit(1);
      run_until_idle(20);
      chk("f_cnt1_wrap", {240'd0, pkt_cnt1}, 0);
      chk("f_cnt0", {240'd0, pkt_cnt0}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
